// File: rtl/bus_uart_tx.sv
// bus_uart_tx: memory-mapped 8N1 UART transmitter on the CPU data bus.
//
// The CPU writes bytes into a TX FIFO. A bit-serial shifter drains the FIFO
// onto the tx pin, holding each bit for a programmable number of clock cycles.
//
// Ports:
//   clock       rising-edge clock shared with the CPU and RAM
//   reset       asynchronous active-low reset
//   bus_sel     decoder select; this block owns the current bus cycle
//   bus_addr    word address; only [1:0] are decoded
//   bus_data_r  registered read data; zero when not selected or on writes
//   bus_data_w  write data
//   bus_mask_w  byte write enables; all-zero means read
//   tx          serial output, idle high
//   busy        high while the FIFO holds data or a frame is in progress
//
// Register map (word offset):
//   0 TXDATA   write mask[0]=1 pushes data[7:0]; reads 0
//   1 STATUS   {count[8+:CW], overflow, busy, empty, full}; write data[3]=1 clears overflow
//   2 DIVISOR  clock cycles per bit, byte-lane writable
//   3 reserved
module bus_uart_tx #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned DIV_WIDTH = 16,
    parameter int unsigned DIV_RESET = 434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        bus_sel,
    input  logic [29:0] bus_addr,
    output logic [31:0] bus_data_r,
    input  logic [31:0] bus_data_w,
    input  logic [3:0]  bus_mask_w,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // FIFO storage and bookkeeping
    logic [7:0]           r_mem [DEPTH];
    logic [AW-1:0]        r_rd_ptr;
    logic [AW-1:0]        r_wr_ptr;
    logic [CW-1:0]        r_count;
    logic                 r_overflow;
    logic [DIV_WIDTH-1:0] r_div;
    logic [31:0]          r_rdata;

    // Shifter
    state_e               r_state;
    logic                 r_tx;
    logic [7:0]           r_shift;
    logic [2:0]           r_bit;
    logic [DIV_WIDTH-1:0] r_cyc;
    logic [DIV_WIDTH-1:0] r_period;

    logic        w_wr;
    logic        w_rd;
    logic        w_push;
    logic        w_pop;
    logic        w_accept;
    logic        w_clr_ovf;
    logic        w_div_wr;
    logic        w_full;
    logic        w_empty;
    logic        w_busy;
    logic        w_bit_end;
    logic [31:0] w_status;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_wr      = bus_sel && (bus_mask_w != 4'b0000);
    assign w_rd      = bus_sel && (bus_mask_w == 4'b0000);
    assign w_push    = w_wr && (bus_addr[1:0] == 2'd0) && bus_mask_w[0];
    assign w_clr_ovf = w_wr && (bus_addr[1:0] == 2'd1) && bus_mask_w[0] && bus_data_w[3];
    assign w_div_wr  = w_wr && (bus_addr[1:0] == 2'd2);

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    // The shifter takes the head byte on the cycle it sits idle with data waiting.
    assign w_pop    = (r_state == StIdle) && !w_empty;
    // A full FIFO can still take a byte if the head leaves in the same cycle.
    assign w_accept = w_push && (!w_full || w_pop);

    assign w_busy    = (r_state != StIdle) || !w_empty;
    assign w_bit_end = (r_cyc == r_period - DIV_WIDTH'(1));

    // Upper address bits and unused data bits are don't-care for this slave.
    assign w_unused = ^{bus_addr[29:2], bus_data_w};

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= bus_data_w[7:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // Sticky until software clears it.
            if (w_push && !w_accept) begin
                r_overflow <= 1'b1;
            end else if (w_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Divisor register, byte-lane writable
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_div <= DIV_WIDTH'(DIV_RESET);
        end else if (w_div_wr) begin
            for (int i = 0; i < int'(DIV_WIDTH); i++) begin
                if (bus_mask_w[i / 8]) begin
                    r_div[i] <= bus_data_w[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: registered, zero unless a read is addressed to us
    // ------------------------------------------------------------------
    always_comb begin
        w_status          = '0;
        w_status[0]       = w_full;
        w_status[1]       = w_empty;
        w_status[2]       = w_busy;
        w_status[3]       = r_overflow;
        w_status[8 +: CW] = r_count;
    end

    always_comb begin
        w_rdata = '0;
        case (bus_addr[1:0])
            2'd1:    w_rdata = w_status;
            2'd2:    w_rdata[DIV_WIDTH-1:0] = r_div;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (w_rd) begin
            r_rdata <= w_rdata;
        end else begin
            r_rdata <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Shifter FSM: START, 8 DATA bits LSB first, STOP; each bit lasts r_period
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= StIdle;
            r_tx     <= 1'b1;
            r_shift  <= '0;
            r_bit    <= '0;
            r_cyc    <= '0;
            r_period <= DIV_WIDTH'(1);
        end else begin
            case (r_state)
                StIdle: begin
                    r_tx <= 1'b1;
                    if (!w_empty) begin
                        r_shift  <= r_mem[r_rd_ptr];
                        // Latched so a mid-frame divisor write only affects later frames.
                        r_period <= (r_div == '0) ? DIV_WIDTH'(1) : r_div;
                        r_bit    <= '0;
                        r_cyc    <= '0;
                        r_tx     <= 1'b0;
                        r_state  <= StStart;
                    end
                end
                StStart: begin
                    if (w_bit_end) begin
                        r_cyc   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= StData;
                    end else begin
                        r_cyc <= r_cyc + DIV_WIDTH'(1);
                    end
                end
                StData: begin
                    if (w_bit_end) begin
                        r_cyc <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= StStop;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_cyc <= r_cyc + DIV_WIDTH'(1);
                    end
                end
                StStop: begin
                    if (w_bit_end) begin
                        r_cyc   <= '0;
                        r_state <= StIdle;
                    end else begin
                        r_cyc <= r_cyc + DIV_WIDTH'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus_data_r = r_rdata;
    assign tx         = r_tx;
    assign busy       = w_busy;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Directed testbench for bus_uart_tx.
module tb_bus_uart_tx;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        bus_sel = 1'b0;
    logic [29:0] bus_addr = '0;
    logic [31:0] bus_data_r;
    logic [31:0] bus_data_w = '0;
    logic [3:0]  bus_mask_w = '0;
    logic        tx;
    logic        busy;

    int tests  = 0;
    int failed = 0;

    bus_uart_tx #(
        .DEPTH    (DEPTH),
        .DIV_WIDTH(16),
        .DIV_RESET(434)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus_sel   (bus_sel),
        .bus_addr  (bus_addr),
        .bus_data_r(bus_data_r),
        .bus_data_w(bus_data_w),
        .bus_mask_w(bus_mask_w),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one bus cycle and returns at the next negedge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
        bus_sel    = 1'b1;
        bus_addr   = {28'b0, a};
        bus_data_w = d;
        bus_mask_w = m;
        @(negedge clock);
        bus_sel    = 1'b0;
        bus_mask_w = 4'b0000;
        bus_data_w = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus_sel    = 1'b1;
        bus_addr   = {28'b0, a};
        bus_mask_w = 4'b0000;
        @(negedge clock);
        d       = bus_data_r;
        bus_sel = 1'b0;
    endtask

    // Checks tx cycle by cycle over one full frame, starting at the current negedge.
    task automatic check_frame(input string tag, input logic [7:0] b, input int p);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < p; c++) begin
                chk(tag, {31'b0, tx}, {31'b0, fr[k]});
                @(negedge clock);
            end
        end
    endtask

    // Receives one frame by sampling near the middle of each bit.
    task automatic rx_byte(input int p, output logic [7:0] b);
        int n;
        n = 0;
        b = '0;
        while (tx !== 1'b0 && n < p * 30) begin
            @(negedge clock);
            n++;
        end
        chk("rx_start_seen", {31'b0, (n < p * 30)}, 32'd1);
        repeat (p / 2) @(negedge clock);
        chk("rx_start_bit", {31'b0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (p) @(negedge clock);
            b[i] = tx;
        end
        repeat (p) @(negedge clock);
        chk("rx_stop_bit", {31'b0, tx}, 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  b;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_rdata", bus_data_r, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        bus_read(2'd1, d);
        chk("status_after_reset", d, 32'h0000_0002);
        chk("idle_tx", {31'b0, tx}, 32'd1);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        bus_read(2'd2, d);
        chk("divisor_after_reset", d, 32'h0000_01B2);
        @(negedge clock);
        chk("deselected_rdata_zero", bus_data_r, 32'd0);
        bus_read(2'd0, d);
        chk("txdata_reads_zero", d, 32'd0);

        // Single frame, divisor 4
        bus_write(2'd2, 32'd4, 4'b0011);
        bus_write(2'd0, 32'h55, 4'b0001);
        chk("tx_high_at_push", {31'b0, tx}, 32'd1);
        @(negedge clock);
        chk("busy_in_frame", {31'b0, busy}, 32'd1);
        check_frame("frame_55", 8'h55, 4);
        chk("tx_idle_after_55", {31'b0, tx}, 32'd1);
        chk("busy_drop_after_55", {31'b0, busy}, 32'd0);

        // Back-to-back frames, divisor 1
        bus_write(2'd2, 32'd1, 4'b0011);
        bus_write(2'd0, 32'hA5, 4'b0001);
        bus_write(2'd0, 32'h3C, 4'b0001);
        check_frame("frame_a5", 8'hA5, 1);
        chk("gap_tx_high", {31'b0, tx}, 32'd1);
        chk("gap_busy", {31'b0, busy}, 32'd1);
        @(negedge clock);
        check_frame("frame_3c", 8'h3C, 1);
        chk("tx_idle_after_3c", {31'b0, tx}, 32'd1);
        chk("busy_drop_after_3c", {31'b0, busy}, 32'd0);

        // Overflow, divisor 100
        bus_write(2'd2, 32'd100, 4'b0011);
        for (int i = 0; i < DEPTH + 2; i++) begin
            bus_write(2'd0, i, 4'b0001);
        end
        bus_read(2'd1, d);
        chk("status_full_overflow", d, 32'h0000_080D);
        bus_write(2'd1, 32'h8, 4'b0001);
        bus_read(2'd1, d);
        chk("status_overflow_cleared", d, 32'h0000_0805);
        for (int i = 0; i < DEPTH + 1; i++) begin
            rx_byte(100, b);
            chk("rx_byte_value", {24'b0, b}, i);
        end
        repeat (200) @(negedge clock);
        chk("no_extra_frame_busy", {31'b0, busy}, 32'd0);
        bus_read(2'd1, d);
        chk("status_drained", d, 32'h0000_0002);

        // Byte-lane divisor writes
        bus_write(2'd2, 32'h0000_01B2, 4'b0011);
        bus_write(2'd2, 32'h0000_00FF, 4'b0001);
        bus_read(2'd2, d);
        chk("div_lane0", d, 32'h0000_01FF);
        bus_write(2'd2, 32'hFFFF_0000, 4'b1100);
        bus_read(2'd2, d);
        chk("div_upper_lanes_ignored", d, 32'h0000_01FF);
        bus_write(2'd2, 32'h0000_AB00, 4'b0010);
        bus_read(2'd2, d);
        chk("div_lane1", d, 32'h0000_ABFF);
        bus_write(2'd0, 32'h77, 4'b0010);
        bus_read(2'd1, d);
        chk("txdata_no_lane0_no_push", d, 32'h0000_0002);
        bus_write(2'd3, 32'hFFFF_FFFF, 4'b1111);
        bus_read(2'd3, d);
        chk("reserved_reads_zero", d, 32'd0);

        // Reset mid-frame during DATA bit 3
        bus_write(2'd2, 32'd4, 4'b0011);
        for (int i = 0; i < DEPTH + 2; i++) begin
            bus_write(2'd0, i, 4'b0001);
        end
        repeat (9) @(negedge clock);
        chk("tx_bit3_low", {31'b0, tx}, 32'd0);
        chk("busy_before_abort", {31'b0, busy}, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("abort_tx_high", {31'b0, tx}, 32'd1);
        chk("abort_busy_low", {31'b0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        bus_read(2'd1, d);
        chk("status_after_abort", d, 32'h0000_0002);
        bus_read(2'd2, d);
        chk("divisor_after_abort", d, 32'h0000_01B2);
        repeat (20) @(negedge clock);
        chk("tx_stays_idle", {31'b0, tx}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/bus_uart_tx.md
Name: bus_uart_tx

Overview:
- Memory-mapped UART transmitter that sits as a slave on the CPU data bus, beside the RAM, behind the address decoder.
- Uses the same bus protocol as the RAM:
  - word address
  - one-cycle registered read data
  - per-byte write mask; a zero mask means read.
- CPU writes bytes into a TX FIFO. A bit-serial shifter drains the FIFO onto the tx pin at a programmable baud rate, using 8N1 framing.

Parameters:
- DEPTH, 8, TX FIFO entries; power of two, at least 2.
- DIV_WIDTH, 16, width of the baud divisor register.
- DIV_RESET, 434, divisor value after reset; clock cycles per bit (50 MHz / 115200).

Ports:
- clock  in  1  rising-edge clock shared with the CPU and RAM.
- reset  in  1  asynchronous, active-low reset.
- bus_sel  in  1  decoder select; this block owns the current bus cycle.
- bus_addr  in  30  word address; only [1:0] decoded, the rest ignored.
- bus_data_r  out  32  registered read data.
- bus_data_w  in  32  write data.
- bus_mask_w  in  4  byte write enables; 0 means read.
- tx  out  1  serial output, idle high.
- busy  out  1  high while the FIFO is non-empty or the shifter is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous), applied immediately:
  - FIFO empty: rd_ptr, wr_ptr and count all 0.
  - overflow=0, divisor=DIV_RESET.
  - state=IDLE, tx=1, busy=0, bus_data_r=0.
- Reset asserted mid-frame aborts the frame: tx returns to 1 immediately and queued bytes are discarded.
- Bus timing: all bus sampling happens on the posedge of clock.
  - bus_sel=0: bus_data_r <= 0. Zero data lets the interconnect OR-combine slave read data.
  - bus_sel=1 and mask==0 (read): bus_data_r <= register[bus_addr[1:0]]. The value is visible exactly one cycle later.
  - bus_sel=1 and mask!=0 (write): bus_data_r <= 0, and the register updates at that same edge.
- Register map (word offset):
  - 0 TXDATA
    - Write with mask[0]=1 pushes bus_data_w[7:0].
    - Writes with mask[0]=0 are ignored.
    - Reads return 0.
  - 1 STATUS (read)
    - bit0 full
    - bit1 empty
    - bit2 busy
    - bit3 overflow
    - bits[8+:$clog2(DEPTH)+1] count
    - all other bits 0.
  - 1 STATUS (write): mask[0]=1 with bus_data_w[3]=1 clears overflow; all other bits are ignored.
  - 2 DIVISOR
    - Read returns divisor zero-extended to 32 bits.
    - Write updates each byte lane whose mask bit is set; bits at or above DIV_WIDTH are ignored.
  - 3 reserved: reads return 0, writes are ignored.
- FIFO push/pop rules:
  - A push is accepted when count<DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set. overflow is sticky until cleared or reset.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- Shifter state machine, states IDLE, START, DATA, STOP:
  - The bit period P is max(latched divisor, 1) clock cycles.
  - IDLE: tx=1. If the FIFO is non-empty:
    - pop the head into the shift register;
    - latch the divisor;
    - clear the bit counter and cycle counter;
    - go to START.
  - START: tx=0 for P cycles, then go to DATA.
  - DATA: tx=shift[0] for P cycles per bit; shift right after each bit. After 8 bits (LSB first), go to STOP.
  - STOP: tx=1 for P cycles, then go to IDLE.
  - Back-to-back bytes: each frame occupies 10*P cycles plus exactly 1 IDLE cycle between frames.
  - A divisor write mid-frame does not affect the current frame; it applies from the next pop.
- tx and busy are driven from registers; no combinational path from the bus to tx.
- busy = (state!=IDLE) || (count!=0). It is registered-equivalent, deriving only from flops.
- Reads of STATUS reflect state before the same-edge update (read-then-update semantics). Example: a push and a STATUS read cannot occur in the same cycle, since the bus carries one access per cycle.

Test Plan:
- Reset, then read STATUS and DIVISOR (bus_sel=1, mask=0):
  - cycle+1 data = 0x00000002 (empty=1), then 434 (0x1B2);
  - tx=1, busy=0 throughout.
- Write DIVISOR=4, then TXDATA=0x55:
  - tx goes low one cycle after the push edge;
  - bit sequence 0,1,0,1,0,1,0,1,0,1, 4 cycles each (40 cycles total);
  - busy drops the cycle the FIFO is empty and the state returns to IDLE.
- Divisor=1, push 0xA5 and 0x3C back-to-back: two frames of 10 cycles separated by exactly 1 idle-high cycle; payload bits sent LSB first.
- Divisor=100, push DEPTH+2 bytes (0x00..0x09):
  - STATUS shows full=1 and overflow=1;
  - count=DEPTH once the first pop is accounted for;
  - exactly DEPTH+1 bytes are transmitted (0x00..0x08);
  - a write of 0x8 to STATUS clears overflow.
- Byte-lane DIVISOR writes:
  - mask=4'b0001, data 0x000000FF -> DIVISOR reads 0x01FF, starting from 0x01B2;
  - mask=4'b1100 -> value unchanged (DIV_WIDTH=16).
- Assert reset=0 mid-DATA bit 3: tx=1 and busy=0 with no clock edge; after release STATUS reads empty=1, overflow=0, divisor=434.
